// File: rtl/io_cdc_pkg.sv
// Shared encodings for the io_cdc responder: access sizes, register offsets
// and write-handshake states.
package io_cdc_pkg;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_B    = 2'd1;
    localparam logic [1:0] ACC_H    = 2'd2;
    localparam logic [1:0] ACC_W    = 2'd3;

    localparam logic [1:0] IO_CDC_DATA   = 2'd0;
    localparam logic [1:0] IO_CDC_STATUS = 2'd1;
    localparam logic [1:0] IO_CDC_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        ACK
    } wr_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; push when full and pop when empty are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = count[DEPTH_LOG2];
    assign head    = mem[rd_ptr];
    // full is the pre-edge state, so a same-cycle pop never frees room for a push
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_cdc.sv
// Memory-mapped bridge between CPU loads/stores and the USB CDC byte streams:
// RX FIFO for host->device bytes, TX FIFO for device->host bytes.
module io_cdc
    import io_cdc_pkg::*;
#(
    parameter logic [31:0] MAP_ZERO        = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  acc_r_i,
    input  logic [31:0] addr_r_i,
    input  logic        sext_i,
    output logic [31:0] data_r_o,
    input  logic        wr_en_i,
    input  logic [1:0]  acc_w_i,
    input  logic [31:0] addr_w_i,
    input  logic [31:0] data_w_i,
    output logic        wr_ready_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    input  logic [7:0]  out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o,
    output logic        rx_irq_o
);

    logic [7:0]                 rx_head;
    logic                       rx_empty;
    logic                       rx_full;
    logic [FIFO_DEPTH_LOG2:0]   rx_count;
    logic                       rx_push;
    logic                       rx_pop;
    logic                       tx_empty;
    logic                       tx_full;
    logic [FIFO_DEPTH_LOG2:0]   tx_count;
    logic                       tx_push;
    logic                       tx_pop;

    logic                       hit_r;
    logic                       hit_w;
    logic                       rd_req;
    logic [1:0]                 rsel;
    logic [1:0]                 wsel;
    logic [31:0]                reg_val;
    logic [31:0]                shifted;
    logic [31:0]                rd_val;
    logic                       irq_en;
    wr_state_e                  state;
    logic                       unused;

    assign hit_r  = (addr_r_i[31:4] == MAP_ZERO[31:4]);
    assign hit_w  = (addr_w_i[31:4] == MAP_ZERO[31:4]);
    assign rsel   = addr_r_i[3:2];
    assign wsel   = addr_w_i[3:2];
    assign rd_req = (acc_r_i != ACC_NONE) && hit_r;

    assign rx_push     = out_valid_i && out_ready_o;
    assign rx_pop      = rd_req && (rsel == IO_CDC_DATA);
    assign tx_pop      = in_valid_o && in_ready_i;
    assign out_ready_o = !rx_full;
    assign in_valid_o  = !tx_empty;
    assign rx_irq_o    = !rx_empty && irq_en;
    assign unused      = ^{acc_w_i, addr_w_i[1:0], data_w_i[31:8], tx_count};

    byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (out_data_i),
        .head   (rx_head),
        .empty  (rx_empty),
        .full   (rx_full),
        .count  (rx_count)
    );

    byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (data_w_i[7:0]),
        .head   (in_data_o),
        .empty  (tx_empty),
        .full   (tx_full),
        .count  (tx_count)
    );

    always_comb begin
        reg_val = '0;
        case (rsel)
            IO_CDC_DATA: begin
                if (!rx_empty) reg_val[7:0] = rx_head;
            end
            IO_CDC_STATUS: begin
                reg_val[0]    = !rx_empty;
                reg_val[1]    = !tx_full;
                reg_val[2]    = tx_empty;
                reg_val[15:8] = 8'(rx_count);
            end
            IO_CDC_CTRL: reg_val[0] = irq_en;
            default:     reg_val = '0;
        endcase
    end

    assign shifted = reg_val >> {addr_r_i[1:0], 3'b000};

    always_comb begin
        rd_val = '0;
        case (acc_r_i)
            ACC_B:   rd_val = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            ACC_H:   rd_val = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            ACC_W:   rd_val = shifted;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_r_o <= '0;
        end else begin
            data_r_o <= rd_req ? rd_val : '0;
        end
    end

    // TX push must reach the FIFO in the same cycle the FSM decides it
    always_comb begin
        tx_push = 1'b0;
        if (state == IDLE && wr_en_i && hit_w && wsel == IO_CDC_DATA && !tx_full) begin
            tx_push = 1'b1;
        end else if (state == WAIT_SPACE && !tx_full) begin
            tx_push = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            wr_ready_o <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            wr_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en_i && hit_w) begin
                        if (wsel == IO_CDC_DATA && tx_full) begin
                            state <= WAIT_SPACE;
                        end else begin
                            if (wsel == IO_CDC_CTRL) irq_en <= data_w_i[0];
                            state      <= ACK;
                            wr_ready_o <= 1'b1;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (!tx_full) begin
                        state      <= ACK;
                        wr_ready_o <= 1'b1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_cdc.sv
// Directed bench for io_cdc: reads and TX bytes are checked by a scoreboard monitor.
module tb_io_cdc;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rstn;
    logic [1:0]  acc_r;
    logic [31:0] addr_r;
    logic        sext;
    logic [31:0] data_r;
    logic        wr_en;
    logic [1:0]  acc_w;
    logic [31:0] addr_w;
    logic [31:0] data_w;
    logic        wr_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        rx_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic        rd_issue = 1'b0;
    logic        rd_pend  = 1'b0;

    io_cdc #(.MAP_ZERO(BASE), .FIFO_DEPTH_LOG2(3)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .acc_r_i     (acc_r),
        .addr_r_i    (addr_r),
        .sext_i      (sext),
        .data_r_o    (data_r),
        .wr_en_i     (wr_en),
        .acc_w_i     (acc_w),
        .addr_w_i    (addr_w),
        .data_w_i    (data_w),
        .wr_ready_o  (wr_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready),
        .rx_irq_o    (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: read results one cycle after each request, TX bytes on handshake.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_queue: got %h with no expected read", data_r);
            end else begin
                chk("rd_data", data_r, exp_rd.pop_front());
            end
        end else begin
            chk("rd_idle_zero", data_r, 32'h0);
        end
        rd_pend = rd_issue;
        if (in_valid && in_ready) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_queue: got %h with no expected byte", in_data);
            end else begin
                chk("tx_byte", {24'h0, in_data}, {24'h0, exp_tx.pop_front()});
            end
        end
    end

    task automatic rd(input logic [1:0] acc, input logic [31:0] addr, input logic sx,
                      input logic [31:0] exp);
        @(posedge clk); #1;
        acc_r = acc; addr_r = addr; sext = sx; rd_issue = 1'b1;
        exp_rd.push_back(exp);
        @(posedge clk); #1;
        acc_r = 2'd0; rd_issue = 1'b0;
    endtask

    // exp_lat < 0 means no acknowledge may appear
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int exp_lat);
        int   lat;
        logic got;
        if (addr == BASE) exp_tx.push_back(data[7:0]);
        @(posedge clk); #1;
        wr_en = 1'b1; acc_w = 2'd3; addr_w = addr; data_w = data;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            if (wr_ready) got = 1'b1;
            else lat++;
        end
        if (exp_lat < 0) chk("wr_no_ack", {31'h0, got}, 32'h0);
        else chk("wr_ack_lat", got ? 32'(lat) : 32'd99, 32'(exp_lat));
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr_ack_pulse", {31'h0, wr_ready}, 32'h0);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        out_valid = 1'b1; out_data = b;
        @(posedge clk); #1;
        out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        acc_r = 2'd0; addr_r = '0; sext = 1'b0;
        wr_en = 1'b0; acc_w = 2'd0; addr_w = '0; data_w = '0;
        in_ready = 1'b0; out_data = '0; out_valid = 1'b0;
        #12;
        chk("rst_data_r", data_r, 32'h0);
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("rst_rx_irq", {31'h0, rx_irq}, 32'h0);
        chk("rst_in_valid", {31'h0, in_valid}, 32'h0);
        chk("rst_in_data", {24'h0, in_data}, 32'h0);
        chk("rst_out_ready", {31'h0, out_ready}, 32'h1);
        @(negedge clk);
        rstn = 1'b1;

        // Decode
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0006);
        rd(2'd3, BASE + 32'h10, 1'b0, 32'h0);
        rd(2'd3, BASE + 32'hC, 1'b0, 32'h0);
        rd(2'd3, BASE + 32'h8, 1'b0, 32'h0);
        wr(BASE + 32'h10, 32'h5A, -1);

        // Loopback with irq enabled
        wr(BASE + 32'h8, 32'h1, 1);
        rd(2'd3, BASE + 32'h8, 1'b0, 32'h1);
        send(8'h41);
        chk("irq_on", {31'h0, rx_irq}, 32'h1);
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0107);
        rd(2'd1, BASE + 32'h5, 1'b0, 32'h0000_0001);
        rd(2'd1, BASE, 1'b1, 32'h0000_0041);
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0006);
        chk("irq_off", {31'h0, rx_irq}, 32'h0);
        rd(2'd3, BASE, 1'b0, 32'h0);

        // TX drain and sign extension
        wr(BASE, 32'h1FF, 1);
        repeat (3) begin
            @(negedge clk);
            chk("tx_hold_valid", {31'h0, in_valid}, 32'h1);
            chk("tx_hold_data", {24'h0, in_data}, 32'hFF);
        end
        @(posedge clk); #1; in_ready = 1'b1;
        @(posedge clk); #1; in_ready = 1'b0;
        chk("tx_drained", {31'h0, in_valid}, 32'h0);
        send(8'hFF);
        rd(2'd1, BASE, 1'b1, 32'hFFFF_FFFF);
        send(8'h80);
        rd(2'd2, BASE, 1'b1, 32'h0000_0080);
        send(8'h80);
        rd(2'd1, BASE, 1'b0, 32'h0000_0080);

        // TX full stall
        for (int i = 0; i < 8; i++) wr(BASE, 32'h10 + 32'(i), 1);
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0000);
        fork
            wr(BASE, 32'h18, 4);
            begin
                repeat (3) @(posedge clk);
                #1 in_ready = 1'b1;
                @(posedge clk); #1 in_ready = 1'b0;
            end
        join
        @(posedge clk); #1; in_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1; in_ready = 1'b0;
        chk("tx_all_out", 32'(exp_tx.size()), 32'h0);
        chk("tx_empty_valid", {31'h0, in_valid}, 32'h0);

        // RX full
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            out_valid = 1'b1; out_data = 8'h51 + 8'(i);
        end
        @(posedge clk); #1;
        out_data = 8'h59;
        chk("rx_full_ready", {31'h0, out_ready}, 32'h0);
        chk("rx_full_irq", {31'h0, rx_irq}, 32'h1);
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0807);
        rd(2'd1, BASE + 32'h5, 1'b1, 32'h0000_0008);
        chk("rx_held_off", {31'h0, out_ready}, 32'h0);
        rd(2'd1, BASE, 1'b0, 32'h51);
        chk("rx_ready_back", {31'h0, out_ready}, 32'h1);
        @(posedge clk); #1; out_valid = 1'b0;
        for (int i = 0; i < 8; i++) rd(2'd1, BASE, 1'b0, 32'h52 + 32'(i));
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0006);

        // Reset in WAIT_SPACE
        send(8'h77);
        for (int i = 0; i < 8; i++) wr(BASE, 32'h60 + 32'(i), 1);
        @(posedge clk); #1;
        wr_en = 1'b1; addr_w = BASE; data_w = 32'h99;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        exp_tx.delete();
        chk("mid_in_valid", {31'h0, in_valid}, 32'h0);
        chk("mid_out_ready", {31'h0, out_ready}, 32'h1);
        chk("mid_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("mid_rx_irq", {31'h0, rx_irq}, 32'h0);
        wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_ack", {31'h0, wr_ready}, 32'h0);
        end
        rd(2'd3, BASE + 32'h4, 1'b0, 32'h0000_0006);
        rd(2'd3, BASE + 32'h8, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("rd_all_seen", 32'(exp_rd.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
